// File: rtl/arm_fetch_pkg.sv
// rtl/arm_fetch_pkg.sv - shared types and constants for the ARM fetch stage
package arm_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    // MOV R0,R0: the bubble presented to decode when no real instruction is available
    localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

    // Clears bits[1:0] so every instruction address stays word-aligned
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_stage_pipe_fetch_deco.sv
// rtl/fetch_stage_pipe_fetch_deco.sv - fetch/decode pipeline register with stall, flush and valid
module pipe_fetch_deco
    import arm_fetch_pkg::*;
#(
    parameter logic [31:0] BUBBLE        = NOP_INSTR,
    parameter logic [31:0] RESET_PCPLUS8 = 32'h0000_0008
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] instr_d,
    input  logic [31:0] pc_plus8_d,
    output logic [31:0] instr_q,
    output logic [31:0] pc_plus8_q,
    output logic        valid_q
);

    // Flush beats stall; an unstalled cycle without a load inserts a bubble and keeps the old PC+8
    always_ff @(posedge clk) begin
        if (!resetn) begin
            instr_q    <= BUBBLE;
            pc_plus8_q <= RESET_PCPLUS8;
            valid_q    <= 1'b0;
        end else if (flush) begin
            instr_q <= BUBBLE;
            valid_q <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                instr_q    <= instr_d;
                pc_plus8_q <= pc_plus8_d;
                valid_q    <= 1'b1;
            end else begin
                instr_q <= BUBBLE;
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, instruction-memory handshake FSM and redirect handling
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = arm_fetch_pkg::NOP_INSTR
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenE,
    input  logic [31:0] ALUResultE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    output logic [31:0] ImemAddr,
    output logic        ImemReq,
    input  logic [31:0] ImemRdata,
    input  logic        ImemAck,
    output logic [31:0] Instruction,
    output logic [31:0] PCPlus8D,
    output logic        ValidD
);

    import arm_fetch_pkg::fetch_state_t;
    import arm_fetch_pkg::S_IDLE;
    import arm_fetch_pkg::S_REQ;
    import arm_fetch_pkg::S_HOLD;
    import arm_fetch_pkg::WORD_MASK;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  buf_q, buf_d;
    logic         pend_valid_q, pend_valid_d;
    logic [31:0]  pend_target_q, pend_target_d;
    logic         deliver;
    logic         redirect;
    logic         stall_any;
    logic [31:0]  target;
    logic [31:0]  fetched_word;

    // Execute-stage branch outranks the writeback PC write
    assign redirect     = BranchTakenE | PCSrcW;
    assign target       = (BranchTakenE ? ALUResultE : ResultW) & WORD_MASK;
    assign stall_any    = StallF | StallD;
    assign fetched_word = (state_q == S_HOLD) ? buf_q : ImemRdata;

    // Request and address come straight from state so they stay stable until the ack
    assign ImemReq  = (state_q == S_REQ);
    assign ImemAddr = pc_q;

    // State, PC, holding buffer and pending-redirect registers
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC & WORD_MASK;
            buf_q         <= NOP_INSTR;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            buf_q         <= buf_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    // Next-state, next-PC and delivery decision
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        buf_d         = buf_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        deliver       = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Any ack seen here belongs to a request abandoned by reset
                state_d      = S_REQ;
                pend_valid_d = 1'b0;
                if (redirect) begin
                    pc_d = target;
                end
            end
            S_REQ: begin
                if (ImemAck) begin
                    pend_valid_d = 1'b0;
                    if (redirect) begin
                        pc_d = target;
                    end else if (pend_valid_q) begin
                        pc_d = pend_target_q;
                    end else if (stall_any) begin
                        buf_d   = ImemRdata;
                        state_d = S_HOLD;
                    end else begin
                        deliver = 1'b1;
                        pc_d    = pc_q + 32'd4;
                    end
                end else if (redirect) begin
                    // Address must not move mid-request; remember the newest target
                    pend_valid_d  = 1'b1;
                    pend_target_d = target;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (!stall_any) begin
                    deliver = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    pipe_fetch_deco #(
        .BUBBLE        (NOP_INSTR),
        .RESET_PCPLUS8 (RESET_PC + 32'd8)
    ) u_pipe_fetch_deco (
        .clk        (Clk),
        .resetn     (Rst),
        .stall      (StallD),
        .flush      (FlushD),
        .load       (deliver),
        .instr_d    (fetched_word),
        .pc_plus8_d (pc_q + 32'd8),
        .instr_q    (Instruction),
        .pc_plus8_q (PCPlus8D),
        .valid_q    (ValidD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        StallF, StallD, FlushD;
    logic        BranchTakenE, PCSrcW;
    logic [31:0] ALUResultE, ResultW;
    logic [31:0] ImemAddr, ImemRdata;
    logic        ImemReq, ImemAck;
    logic [31:0] Instruction, PCPlus8D;
    logic        ValidD;

    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        force_ack = 1'b0;
    int          lat = 1;
    int          cnt = 0;
    int          vec_cnt = 0;
    int          err_cnt = 0;

    fetch_stage dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .BranchTakenE (BranchTakenE),
        .ALUResultE   (ALUResultE),
        .PCSrcW       (PCSrcW),
        .ResultW      (ResultW),
        .ImemAddr     (ImemAddr),
        .ImemReq      (ImemReq),
        .ImemRdata    (ImemRdata),
        .ImemAck      (ImemAck),
        .Instruction  (Instruction),
        .PCPlus8D     (PCPlus8D),
        .ValidD       (ValidD)
    );

    always #5 Clk = ~Clk;

    assign ImemAck   = mem_ack | force_ack;
    assign ImemRdata = force_ack ? 32'hDEAD_BEE0 : mem_rdata;

    // Memory model: acks the lat-th cycle of a request, data = addr | 0xE000_0000
    always @(negedge Clk) begin
        if (ImemReq) begin
            cnt = cnt + 1;
            if (cnt >= lat) begin
                mem_ack   = 1'b1;
                mem_rdata = ImemAddr | 32'hE000_0000;
                cnt       = 0;
            end else begin
                mem_ack = 1'b0;
            end
        end else begin
            mem_ack = 1'b0;
            cnt     = 0;
        end
    end

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic reset_dut();
        Rst = 1'b0;
        step();
        step();
        Rst = 1'b1;
        step();
    endtask

    initial begin
        Rst = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        BranchTakenE = 1'b0; PCSrcW = 1'b0; ALUResultE = 32'h0; ResultW = 32'h0;

        // Reset state, zero-wait memory
        lat = 1;
        step();
        step();
        check32("rst_req", ImemReq, 0);
        check32("rst_instr", Instruction, NOP);
        check32("rst_pc8", PCPlus8D, 32'h8);
        check32("rst_valid", ValidD, 0);
        Rst = 1'b1;
        step();
        check32("zw_req0", ImemReq, 1);
        check32("zw_addr0", ImemAddr, 32'h0);
        check32("zw_valid0", ValidD, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check32("zw_instr", Instruction, 32'hE000_0000 | (k * 4));
            check32("zw_pc8", PCPlus8D, k * 4 + 8);
            check32("zw_valid", ValidD, 1);
            check32("zw_addr", ImemAddr, k * 4 + 4);
        end

        // Three-cycle latency memory
        lat = 3;
        reset_dut();
        check32("l3_addr0", ImemAddr, 32'h0);
        step(); check32("l3_v1", ValidD, 0);
        step(); check32("l3_addr_hold", ImemAddr, 32'h0);
        step();
        check32("l3_instr0", Instruction, 32'hE000_0000);
        check32("l3_pc8_0", PCPlus8D, 32'h8);
        check32("l3_valid0", ValidD, 1);
        check32("l3_addr4a", ImemAddr, 32'h4);
        step();
        check32("l3_addr4b", ImemAddr, 32'h4);
        check32("l3_req4b", ImemReq, 1);
        check32("l3_bubble", Instruction, NOP);
        check32("l3_bvalid", ValidD, 0);
        step(); check32("l3_addr4c", ImemAddr, 32'h4);
        step();
        check32("l3_instr4", Instruction, 32'hE000_0004);
        check32("l3_pc8_4", PCPlus8D, 32'hC);
        check32("l3_valid4", ValidD, 1);

        // Stall across an ack: word parked in S_HOLD, delivered once after release
        StallF = 1'b1; StallD = 1'b1;
        step(); check32("st_hold_i1", Instruction, 32'hE000_0004); check32("st_addr1", ImemAddr, 32'h8);
        step(); check32("st_hold_v2", ValidD, 1);
        step(); check32("st_noreq3", ImemReq, 0); check32("st_hold_i3", Instruction, 32'hE000_0004);
        step(); check32("st_noreq4", ImemReq, 0);
        StallF = 1'b0; StallD = 1'b0;
        step();
        check32("st_rel_instr", Instruction, 32'hE000_0008);
        check32("st_rel_pc8", PCPlus8D, 32'h10);
        check32("st_rel_valid", ValidD, 1);
        check32("st_rel_addr", ImemAddr, 32'hC);
        check32("st_rel_req", ImemReq, 1);
        step(); check32("st_nodup", ValidD, 0);
        step();
        step();
        check32("st_next_instr", Instruction, 32'hE000_000C);
        check32("st_next_pc8", PCPlus8D, 32'h14);

        // Pending redirects during a latency-3 wait, newest target wins
        reset_dut();
        BranchTakenE = 1'b1; ALUResultE = 32'h40;
        step(); check32("br_addr_held", ImemAddr, 32'h0);
        ALUResultE = 32'h20;
        step();
        BranchTakenE = 1'b0;
        step();
        check32("br_addr20", ImemAddr, 32'h20);
        check32("br_drop0", ValidD, 0);
        BranchTakenE = 1'b1; ALUResultE = 32'h100;
        step(); check32("br_mid_addr", ImemAddr, 32'h20);
        BranchTakenE = 1'b0;
        step(); check32("br_mid_addr2", ImemAddr, 32'h20);
        step();
        check32("br_addr100", ImemAddr, 32'h100);
        check32("br_drop20", ValidD, 0);
        check32("br_drop20_i", Instruction, NOP);
        step(); step(); step();
        check32("br_instr100", Instruction, 32'hE000_0100);
        check32("br_pc8_100", PCPlus8D, 32'h108);

        // Branch beats PC write; flush beats stall on the fetch/decode register
        BranchTakenE = 1'b1; ALUResultE = 32'h200;
        PCSrcW = 1'b1; ResultW = 32'h300;
        FlushD = 1'b1; StallD = 1'b1;
        step();
        check32("fl_instr", Instruction, NOP);
        check32("fl_valid", ValidD, 0);
        check32("fl_pc8", PCPlus8D, 32'h108);
        BranchTakenE = 1'b0; PCSrcW = 1'b0; FlushD = 1'b0; StallD = 1'b0;
        step(); check32("pri_addr_held", ImemAddr, 32'h104);
        step();
        check32("pri_addr200", ImemAddr, 32'h200);
        check32("pri_valid", ValidD, 0);

        // Reset mid-request, with an ack arriving during and just after reset
        Rst = 1'b0; force_ack = 1'b1;
        step();
        check32("mr_req", ImemReq, 0);
        check32("mr_valid", ValidD, 0);
        check32("mr_pc8", PCPlus8D, 32'h8);
        Rst = 1'b1;
        step();
        force_ack = 1'b0;
        check32("mr_addr", ImemAddr, 32'h0);
        check32("mr_req2", ImemReq, 1);
        check32("mr_ign", ValidD, 0);
        step(); step(); step();
        check32("mr_instr", Instruction, 32'hE000_0000);
        check32("mr_valid2", ValidD, 1);

        // Unaligned branch target is masked; PC+4 wraps past 0xFFFF_FFFC
        lat = 1;
        reset_dut();
        BranchTakenE = 1'b1; ALUResultE = 32'hFFFF_FFFF;
        step();
        BranchTakenE = 1'b0;
        check32("wr_addr", ImemAddr, 32'hFFFF_FFFC);
        check32("wr_drop", ValidD, 0);
        step();
        check32("wr_instr", Instruction, 32'hFFFF_FFFC);
        check32("wr_pc8", PCPlus8D, 32'h4);
        check32("wr_addr0", ImemAddr, 32'h0);
        step();
        check32("wr_instr0", Instruction, 32'hE000_0000);
        check32("wr_pc8_0", PCPlus8D, 32'h8);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Front end of the pipelined ARM core; produces the `Instruction`/`PCPlus8D` pair that the decode stage consumes.
- Owns the PC register and an instruction-memory request/acknowledge handshake with variable latency.
- Owns the fetch/decode pipeline register, with stall, flush and branch/PC-write redirect handling.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'hE1A0_0000, bubble instruction (MOV R0,R0) injected on flush or empty slot.

Ports:
- Clk  in  1  core clock; all state updates on rising edge.
- Rst  in  1  synchronous reset, active-low (Rst==0 at a rising edge resets).
- StallF  in  1  hold PC and fetch buffer (from hazard unit).
- StallD  in  1  hold fetch/decode register.
- FlushD  in  1  replace fetch/decode contents with bubble.
- BranchTakenE  in  1  early branch redirect from execute.
- ALUResultE  in  32  branch target from execute.
- PCSrcW  in  1  PC write from writeback (e.g. LDR PC / write to R15).
- ResultW  in  32  target for PCSrcW.
- ImemAddr  out  32  instruction address; word-aligned, bits[1:0]=0.
- ImemReq  out  1  request strobe.
- ImemRdata  in  32  instruction word, valid when ImemAck=1.
- ImemAck  in  1  one-cycle response pulse.
- Instruction  out  32  instruction presented to decode.
- PCPlus8D  out  32  address of Instruction + 8.
- ValidD  out  1  Instruction is real (0 = bubble).

Behaviour:
- Reset (Rst==0 at edge): PC=RESET_PC; state=S_IDLE; ImemReq=0; Instruction=NOP_INSTR; PCPlus8D=RESET_PC+8; ValidD=0; redirect-pending flag cleared. Reset takes effect mid-transaction: an outstanding request is abandoned, and any ImemAck arriving during or after reset while in S_IDLE is ignored.
- States:
  - S_IDLE: entered only from reset; moves to S_REQ the next cycle.
  - S_REQ: ImemReq=1, ImemAddr=PC. Both are held stable until ImemAck. ImemAck is legal in the same cycle as the first ImemReq cycle (zero-wait memory gives 1 instr/cycle).
  - S_HOLD: instruction buffered, waiting for the stall to release; ImemReq=0.
- Next PC priority: BranchTakenE → ALUResultE; else PCSrcW → ResultW; else PC+4. Targets are forced word-aligned (bits[1:0] cleared). PC+4 wraps modulo 2^32.
- Delivery condition: an instruction is available (ImemAck in S_REQ, or S_HOLD), StallF=0, StallD=0, and no redirect this cycle or pending. On delivery:
  - Instruction←word, PCPlus8D←PC+8, ValidD←1.
  - PC←next PC; state→S_REQ (back-to-back requests).
- Available but stalled: buffer the word; state→S_HOLD; PC unchanged.
- Redirect (BranchTakenE|PCSrcW):
  - In S_HOLD or on the ack cycle: the fetched word is discarded; PC←target; state→S_REQ.
  - In S_REQ without ack: the address cannot change. Latch the target into a pending register; when the ack arrives, drop the word, load PC←pending target, issue a new request.
  - A newer redirect overwrites the pending target.
- Fetch/decode register:
  - FlushD=1: Instruction=NOP_INSTR, ValidD=0, PCPlus8D unchanged. FlushD wins over StallD.
  - StallD=1 (no flush): hold all three outputs.
  - Otherwise, with no delivery: bubble (NOP_INSTR, ValidD=0).
- Latency: address→Instruction = memory latency + 1 register stage.

Decomposition:
- Shared package arm_fetch_pkg:
  - fetch_state_t enum {S_IDLE, S_REQ, S_HOLD}.
  - NOP_INSTR constant.
  - WORD_MASK constant (32'hFFFF_FFFC).
- One sub-module pipe_fetch_deco: the fetch/decode register with synchronous active-low reset, stall/flush enables and a valid bit. The PC and FSM stay in fetch_stage.

Test Plan:
- Reset with zero-wait memory (ImemAck every cycle, ImemRdata=addr|0xE000_0000) → ImemAddr 0,4,8…; Instruction 0xE000_0000 with PCPlus8D=8 one cycle after the first ack, then one per cycle.
- 3-cycle latency memory → ImemAddr=4 held for 3 cycles with ImemReq=1; ValidD pulses once per 3 cycles; PCPlus8D=12 for instr@4.
- StallF=StallD=1 for 4 cycles with an ack arriving during the stall → state S_HOLD, no new request, outputs held; delivered the cycle after stall release, with no lost or duplicated instruction.
- BranchTakenE=1, ALUResultE=0x100 in mid-wait of a latency-3 request to 0x20 → word for 0x20 dropped (ValidD=0); next ImemAddr=0x100.
- BranchTakenE and PCSrcW both asserted (0x200 vs 0x300) → ImemAddr 0x200. FlushD with StallD → Instruction=0xE1A0_0000, ValidD=0.
- Rst=0 asserted during an outstanding request, then an ack while in reset → ignored; after release ImemAddr=RESET_PC. PC at 0xFFFF_FFFC wraps to 0x0.
